// File: rtl/l2_arbiter.sv
// l2_arbiter: shares one downstream line-fill port between icache and dcache.
// A grant captures the line-aligned request address and streams WORDS beats
// back to the winner; ties alternate between requesters.
// Optional build macro: L2_ARB_DCACHE_PRIORITY_EN makes every tie go to dcache.
module l2_arbiter #(
    parameter int unsigned LINE_SIZE = 32,
    parameter int unsigned XLEN      = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] icache_address,
    input  logic            icache_access,
    output logic [XLEN-1:0] icache_word,
    output logic            icache_word_valid,
    output logic            icache_done,
    input  logic [XLEN-1:0] dcache_address,
    input  logic            dcache_access,
    output logic [XLEN-1:0] dcache_word,
    output logic            dcache_word_valid,
    output logic            dcache_done,
    output logic [XLEN-1:0] memory_address,
    output logic            memory_access,
    input  logic [XLEN-1:0] memory_word,
    input  logic            memory_word_valid
);

    localparam int unsigned WORDS = LINE_SIZE * 8 / XLEN;
    localparam int unsigned BW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [XLEN-1:0] LINE_MASK = ~XLEN'(LINE_SIZE - 1);
    localparam logic [BW-1:0]   LAST_BEAT = BW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL_I = 2'd1,
        FILL_D = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic            grant_i_c, grant_d_c;
`ifndef L2_ARB_DCACHE_PRIORITY_EN
    // 1 = dcache was granted most recently
    logic            last_grant_q, last_grant_d;
`endif

    // State, beat counter, captured address and fairness history
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            mem_addr_q <= '0;
`ifndef L2_ARB_DCACHE_PRIORITY_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            mem_addr_q <= mem_addr_d;
`ifndef L2_ARB_DCACHE_PRIORITY_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Grant selection, beat forwarding and fill completion
    always_comb begin
        state_d           = state_q;
        beat_d            = beat_q;
        mem_addr_d        = mem_addr_q;
`ifndef L2_ARB_DCACHE_PRIORITY_EN
        last_grant_d      = last_grant_q;
`endif
        grant_i_c         = 1'b0;
        grant_d_c         = 1'b0;
        icache_word       = '0;
        icache_word_valid = 1'b0;
        icache_done       = 1'b0;
        dcache_word       = '0;
        dcache_word_valid = 1'b0;
        dcache_done       = 1'b0;
        memory_access     = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (icache_access && dcache_access) begin
`ifdef L2_ARB_DCACHE_PRIORITY_EN
                    grant_d_c = 1'b1;
`else
                    grant_i_c = last_grant_q;
                    grant_d_c = ~last_grant_q;
`endif
                end else begin
                    grant_i_c = icache_access;
                    grant_d_c = dcache_access;
                end

                if (grant_i_c) begin
                    state_d    = FILL_I;
                    mem_addr_d = icache_address & LINE_MASK;
`ifndef L2_ARB_DCACHE_PRIORITY_EN
                    last_grant_d = 1'b0;
`endif
                end else if (grant_d_c) begin
                    state_d    = FILL_D;
                    mem_addr_d = dcache_address & LINE_MASK;
`ifndef L2_ARB_DCACHE_PRIORITY_EN
                    last_grant_d = 1'b1;
`endif
                end
            end

            FILL_I, FILL_D: begin
                if (memory_word_valid) begin
                    if (state_q == FILL_I) begin
                        icache_word       = memory_word;
                        icache_word_valid = 1'b1;
                        icache_done       = (beat_q == LAST_BEAT);
                    end else begin
                        dcache_word       = memory_word;
                        dcache_word_valid = 1'b1;
                        dcache_done       = (beat_q == LAST_BEAT);
                    end
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    assign memory_address = mem_addr_q;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: a cycle-level ownership model checks every
// output on each negedge; literal expectations pin grant order, addresses,
// beat data and completion counts for each scenario.
module tb_l2_arbiter;

    localparam int unsigned LINE_SIZE = 32;
    localparam int unsigned XLEN      = 32;
    localparam int          WORDS     = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] icache_address = '0, dcache_address = '0;
    logic        icache_access = 1'b0, dcache_access = 1'b0;
    logic [31:0] icache_word, dcache_word, memory_address;
    logic        icache_word_valid, icache_done, dcache_word_valid, dcache_done;
    logic        memory_access;
    logic [31:0] memory_word = '0;
    logic        memory_word_valid = 1'b0;

    always #5 clk = ~clk;

    l2_arbiter #(.LINE_SIZE(LINE_SIZE), .XLEN(XLEN)) dut (
        .clk               (clk),
        .reset             (reset),
        .icache_address    (icache_address),
        .icache_access     (icache_access),
        .icache_word       (icache_word),
        .icache_word_valid (icache_word_valid),
        .icache_done       (icache_done),
        .dcache_address    (dcache_address),
        .dcache_access     (dcache_access),
        .dcache_word       (dcache_word),
        .dcache_word_valid (dcache_word_valid),
        .dcache_done       (dcache_done),
        .memory_address    (memory_address),
        .memory_access     (memory_access),
        .memory_word       (memory_word),
        .memory_word_valid (memory_word_valid)
    );

    // ---------------- behavioural model: owner 0=none, 1=icache, 2=dcache
    int          m_owner, m_cnt, m_last, m_pick;
    logic [31:0] m_addr;

    always @(posedge clk) begin
        if (reset) begin
            m_owner = 0; m_cnt = 0; m_addr = 0; m_last = 2;
        end else if (m_owner == 0) begin
            m_pick = 0;
            if (icache_access && dcache_access) begin
`ifdef L2_ARB_DCACHE_PRIORITY_EN
                m_pick = 2;
`else
                m_pick = (m_last == 2) ? 1 : 2;
`endif
            end else if (icache_access) m_pick = 1;
            else if (dcache_access) m_pick = 2;
            if (m_pick != 0) begin
                m_owner = m_pick;
                m_last  = m_pick;
                m_addr  = (m_pick == 1) ? icache_address : dcache_address;
                m_addr  = m_addr - (m_addr % LINE_SIZE);
            end
        end else if (memory_word_valid) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == WORDS) begin
                m_owner = 0; m_cnt = 0;
            end
        end
    end

    // ---------------- literal expectations posted by the stimulus process
    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } lit_t;
    lit_t lit_q[$];
    int   lit_rd = 0;

    task automatic post(input string n, input logic [31:0] a, input logic [31:0] e);
        lit_t t;
        t.name = n; t.act = a; t.exp = e;
        lit_q.push_back(t);
    endtask

    // ---------------- observation logs (written only by the compare process)
    int          tests = 0, fails = 0, cyc = 0;
    bit          check_en = 1'b0;
    logic        acc_prev = 1'b0;
    logic [31:0] grant_log[$];
    int          rise_cyc[$];
    int          done_cyc[$];
    logic [31:0] i_beats[$];
    int          i_vcnt = 0, d_vcnt = 0, i_done = 0, d_done = 0;
    logic [31:0] i_done_word = '0, d_done_word = '0;
    logic        e_iv, e_dv;

    function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", n, a, e, $time);
        end
    endfunction

    // Per-cycle compare against the model, logging, and literal checks
    always @(negedge clk) begin
        cyc++;
        if (check_en) begin
            e_iv = (m_owner == 1) && memory_word_valid;
            e_dv = (m_owner == 2) && memory_word_valid;
            chk("memory_access", 32'(memory_access), 32'(m_owner != 0));
            chk("memory_address", memory_address, m_addr);
            chk("icache_word", icache_word, e_iv ? memory_word : 32'h0);
            chk("icache_word_valid", 32'(icache_word_valid), 32'(e_iv));
            chk("icache_done", 32'(icache_done), 32'(e_iv && m_cnt == WORDS - 1));
            chk("dcache_word", dcache_word, e_dv ? memory_word : 32'h0);
            chk("dcache_word_valid", 32'(dcache_word_valid), 32'(e_dv));
            chk("dcache_done", 32'(dcache_done), 32'(e_dv && m_cnt == WORDS - 1));
        end
        if (memory_access && !acc_prev) begin
            grant_log.push_back(memory_address);
            rise_cyc.push_back(cyc);
        end
        acc_prev = memory_access;
        if (icache_word_valid) begin i_vcnt++; i_beats.push_back(icache_word); end
        if (dcache_word_valid) d_vcnt++;
        if (icache_done) begin i_done++; i_done_word = icache_word; done_cyc.push_back(cyc); end
        if (dcache_done) begin d_done++; d_done_word = dcache_word; done_cyc.push_back(cyc); end
        while (lit_rd < lit_q.size()) begin
            chk(lit_q[lit_rd].name, lit_q[lit_rd].act, lit_q[lit_rd].exp);
            lit_rd++;
        end
    end

    // ---------------- stimulus helpers (all drive at posedge+2)
    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic wait_grant();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (memory_access) begin ok = 1'b1; break; end
        end
        if (!ok) post("grant_timeout", 32'd0, 32'd1);
        step();
    endtask

    // Drive n beats base+k with gap idle cycles before each; at beat drop_at
    // both accesses drop and both addresses change (must not disturb the fill).
    task automatic send_beats(input logic [31:0] base, input int gap, input int drop_at, input int n);
        for (int b = 0; b < n; b++) begin
            repeat (gap) begin memory_word_valid = 1'b0; step(); end
            memory_word_valid = 1'b1;
            memory_word       = base + 32'(b);
            if (b == drop_at) begin
                icache_access  = 1'b0;
                dcache_access  = 1'b0;
                icache_address = ~icache_address;
                dcache_address = ~dcache_address;
            end
            step();
        end
        memory_word_valid = 1'b0;
        memory_word       = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1; step(); reset = 1'b0;
    endtask

    int          g0, b0, c0, c1, c2, c3, r0, dn0;
    logic [31:0] exp_seq[4];
    logic [31:0] first_a, second_a;

    initial begin
        @(posedge clk); #2;
        check_en = 1'b1;
        step();
        reset = 1'b0;
        post("reset_access", 32'(memory_access), 32'd0);
        post("reset_address", memory_address, 32'd0);
        post("reset_i_valid", 32'(icache_word_valid), 32'd0);
        post("reset_d_done", 32'(dcache_done), 32'd0);

        // Single icache fill with an unaligned address
        g0 = grant_log.size(); b0 = i_beats.size(); c0 = i_done; c1 = d_vcnt;
        icache_address = 32'h0000_1234; icache_access = 1'b1;
        wait_grant();
        send_beats(32'hA0, 0, -1, 8);
        icache_access = 1'b0;
        step();
        post("s1_grants", 32'(grant_log.size() - g0), 32'd1);
        if (grant_log.size() > g0) post("s1_addr", grant_log[g0], 32'h0000_1220);
        post("s1_beats", 32'(i_beats.size() - b0), 32'd8);
        for (int k = 0; k < 8; k++)
            if (i_beats.size() > b0 + k) post("s1_beat", i_beats[b0 + k], 32'hA0 + 32'(k));
        post("s1_done", 32'(i_done - c0), 32'd1);
        post("s1_done_word", i_done_word, 32'hA7);
        post("s1_dvalid", 32'(d_vcnt - c1), 32'd0);

        // Simultaneous requests straight after reset
        do_reset();
        g0 = grant_log.size(); r0 = rise_cyc.size(); dn0 = done_cyc.size();
        icache_address = 32'h100; dcache_address = 32'h200;
        icache_access = 1'b1; dcache_access = 1'b1;
`ifdef L2_ARB_DCACHE_PRIORITY_EN
        first_a = 32'h200; second_a = 32'h100;
`else
        first_a = 32'h100; second_a = 32'h200;
`endif
        wait_grant();
        send_beats(32'hB0, 0, -1, 8);
`ifdef L2_ARB_DCACHE_PRIORITY_EN
        dcache_access = 1'b0;
`else
        icache_access = 1'b0;
`endif
        wait_grant();
        send_beats(32'hC0, 0, -1, 8);
        icache_access = 1'b0; dcache_access = 1'b0;
        step();
        post("s2_grants", 32'(grant_log.size() - g0), 32'd2);
        if (grant_log.size() > g0 + 1) begin
            post("s2_first", grant_log[g0], first_a);
            post("s2_second", grant_log[g0 + 1], second_a);
        end
        if (rise_cyc.size() > r0 + 1 && done_cyc.size() > dn0)
            post("s2_idle_gap", 32'(rise_cyc[r0 + 1] - done_cyc[dn0]), 32'd2);

        // Sustained ties over four fills
        g0 = grant_log.size();
        icache_address = 32'h1000; dcache_address = 32'h2000;
        icache_access = 1'b1; dcache_access = 1'b1;
`ifdef L2_ARB_DCACHE_PRIORITY_EN
        exp_seq[0] = 32'h2000; exp_seq[1] = 32'h2000; exp_seq[2] = 32'h2000; exp_seq[3] = 32'h2000;
`else
        exp_seq[0] = 32'h1000; exp_seq[1] = 32'h2000; exp_seq[2] = 32'h1000; exp_seq[3] = 32'h2000;
`endif
        for (int f = 0; f < 4; f++) begin
            wait_grant();
            send_beats(32'h10 * 32'(f), 0, (f == 3) ? 0 : -1, 8);
        end
        step();
        post("s3_grants", 32'(grant_log.size() - g0), 32'd4);
        for (int f = 0; f < 4; f++)
            if (grant_log.size() > g0 + f) post("s3_order", grant_log[g0 + f], exp_seq[f]);

        // Stray beats in IDLE, then a gapped dcache fill
        icache_address = 32'h0; dcache_address = 32'h0;
        c0 = i_vcnt; c1 = d_vcnt; c2 = d_done; g0 = grant_log.size();
        memory_word_valid = 1'b1; memory_word = 32'hDEAD;
        repeat (3) step();
        memory_word_valid = 1'b0;
        post("s4_idle_ivalid", 32'(i_vcnt - c0), 32'd0);
        post("s4_idle_dvalid", 32'(d_vcnt - c1), 32'd0);
        post("s4_idle_access", 32'(memory_access), 32'd0);
        dcache_address = 32'h345; dcache_access = 1'b1;
        wait_grant();
        send_beats(32'h300, 2, -1, 8);
        dcache_access = 1'b0;
        memory_word_valid = 1'b1; memory_word = 32'hBEEF;
        repeat (2) step();
        memory_word_valid = 1'b0;
        post("s4_dvalid", 32'(d_vcnt - c1), 32'd8);
        post("s4_done", 32'(d_done - c2), 32'd1);
        post("s4_done_word", d_done_word, 32'h307);
        if (grant_log.size() > g0) post("s4_addr", grant_log[g0], 32'h340);

        // Granted access dropped mid-fill (addresses also change)
        c0 = i_vcnt; c1 = i_done;
        icache_address = 32'h500; icache_access = 1'b1;
        wait_grant();
        send_beats(32'hE0, 0, 2, 8);
        step();
        post("s5_ivalid", 32'(i_vcnt - c0), 32'd8);
        post("s5_done", 32'(i_done - c1), 32'd1);
        post("s5_done_word", i_done_word, 32'hE7);

        // Reset after four beats of a dcache fill, then a fresh icache fill
        icache_address = 32'h0; dcache_address = 32'h600;
        c0 = d_done; c1 = i_done; c3 = d_vcnt;
        dcache_access = 1'b1;
        wait_grant();
        send_beats(32'hF0, 0, -1, 4);
        reset = 1'b1; dcache_access = 1'b0;
        memory_word_valid = 1'b1; memory_word = 32'h55;
        step();
        reset = 1'b0;
        post("s6_access", 32'(memory_access), 32'd0);
        post("s6_address", memory_address, 32'd0);
        post("s6_d_word", dcache_word, 32'd0);
        post("s6_d_valid", 32'(dcache_word_valid), 32'd0);
        post("s6_i_valid", 32'(icache_word_valid), 32'd0);
        repeat (2) step();
        memory_word_valid = 1'b0;
        post("s6_no_done", 32'(d_done - c0), 32'd0);
        post("s6_dvalid", 32'(d_vcnt - c3), 32'd5);
        g0 = grant_log.size();
        icache_address = 32'h700; icache_access = 1'b1;
        wait_grant();
        send_beats(32'h70, 0, -1, 8);
        icache_access = 1'b0;
        step();
        if (grant_log.size() > g0) post("s6_addr", grant_log[g0], 32'h700);
        post("s6_i_done", 32'(i_done - c1), 32'd1);

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
